ysyx_24100006_rd_arbiter: RTL and testbench
===========================================

Name: ysyx_24100006_rd_arbiter

Overview:
- 2:1 AXI read-channel arbiter sharing the single memory AR/R port between IFU (instruction fetch) and LSU/MEMU (loads).
- Sits between the fetch and memory stages and the SoC bus. LSU write channels (AW/W/B) bypass the arbiter.
- The arbiter only watches the write handshakes, so no new read starts while a store is in flight (store→load and store→fetch ordering).
- Single-beat reads only (ARLEN=0 driven outside).

Parameters:
- MAX_LSU_STREAK, 4: consecutive contested LSU wins allowed before IFU is forced through; legal range ≥1.
- SW: $clog2(MAX_LSU_STREAK+1), derived width of the streak counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ifu_araddr  in  32  IFU read address
- ifu_arvalid  in  1  IFU read request
- ifu_arready  out  1  IFU request accepted (grant)
- ifu_rdata  out  32  read data (broadcast of m_rdata)
- ifu_rvalid  out  1  read data valid to IFU
- ifu_rready  in  1  IFU accepts data
- lsu_araddr  in  32  LSU read address
- lsu_arsize  in  3  LSU read size
- lsu_arvalid  in  1  LSU read request
- lsu_arready  out  1  LSU request accepted (grant)
- lsu_rdata  out  32  read data (broadcast of m_rdata)
- lsu_rvalid  out  1  read data valid to LSU
- lsu_rready  in  1  LSU accepts data
- m_araddr  out  32  bus read address
- m_arsize  out  3  bus read size
- m_arvalid  out  1  bus read address valid
- m_arready  in  1  bus read address ready
- m_rdata  in  32  bus read data
- m_rvalid  in  1  bus read data valid
- m_rready  out  1  bus read data ready
- m_awvalid  in  1  observed: write address valid
- m_awready  in  1  observed: write address ready
- m_bvalid  in  1  observed: write response valid
- m_bready  in  1  observed: write response ready
- arb_busy  out  1  high whenever state≠IDLE

Behaviour:
- States: IDLE, IFU_AR, IFU_R, LSU_AR, LSU_R.
- Reset: async; all of the following take effect immediately:
  - state=IDLE, m_araddr=0, m_arsize=3'b010, m_arvalid=0, wr_pend=0, streak=0.
  - All combinational outputs then evaluate to 0.
  - Reset mid-transaction abandons the transfer; no recovery.
- wr_pend:
  - Set on m_awvalid&&m_awready; cleared on m_bvalid&&m_bready.
  - If set and clear occur in the same cycle, clear wins only if wr_pend was already 1; otherwise set.
- blocked = wr_pend | m_awvalid.
- Grant (combinational, only in IDLE and !blocked):
  - Only one requester valid: grant it.
  - Both valid: grant IFU if streak==MAX_LSU_STREAK, else grant LSU.
- ifu_arready / lsu_arready = 1 only in the cycle of their grant; never both in the same cycle.
- On the grant edge:
  - m_araddr <= granted address.
  - m_arsize <= lsu_arsize for LSU, 3'b010 for IFU.
  - m_arvalid <= 1.
  - state <= IFU_AR or LSU_AR.
  - Request-to-m_arvalid latency is 1 cycle.
- x_AR state:
  - m_arvalid stays held with stable address until m_arready.
  - On m_arready: m_arvalid <= 0, state <= x_R.
- x_R state:
  - Combinational pass-through: x_rvalid=m_rvalid, m_rready=x_rready.
  - The non-granted rvalid stays 0.
  - On m_rvalid&&m_rready: state <= IDLE.
  - A new grant is possible in the following cycle, giving a minimum back-to-back issue interval of 3 cycles at zero bus wait.
- m_rready=0 outside the x_R states. A spurious m_rvalid outside x_R is ignored and not forwarded.
- Streak counter, updated only on grant edges:
  - LSU granted while ifu_arvalid=1: streak+1, saturating at MAX.
  - LSU granted while ifu_arvalid=0: streak=0.
  - IFU granted: streak=0.
- rdata is a combinational broadcast of m_rdata to both masters; consumers qualify it with their own rvalid.
- Request deassertion:
  - A request dropped before grant is lost; no state change.
  - Once granted, the address is captured, so the requester may drop arvalid.
- Writes may be accepted by the bus while a read is outstanding. wr_pend only gates new grants, never in-flight reads.

Test Plan:
- Lone IFU read, addr 0x3000_0000, m_arready 2 cycles late, m_rdata=0xDEADBEEF after 3 cycles → ifu_arready pulse at cycle 0, m_arvalid cycles 1–3 with m_arsize=3'b010, ifu_rvalid with 0xDEADBEEF, lsu_rvalid=0 throughout, back to IDLE.
- Simultaneous IFU+LSU requests held continuously, MAX=4, zero-wait slave → grant order L,L,L,L,I,L,L,L,L,I; streak returns to 0 after each IFU grant.
- Store in flight: AW handshake at cycle 0, bvalid at cycle 6, LSU read requested at cycle 1 → no lsu_arready before cycle 7, m_arvalid first high at cycle 8.
- LSU LB at 0x8000_0003 with lsu_arsize=3'b000 → m_araddr=0x8000_0003, m_arsize=3'b000; data forwarded only to LSU.
- Assert reset while in LSU_R with m_rvalid pending → m_arvalid=0, m_rready=0, lsu_rvalid=0, arb_busy=0 immediately (asynchronous); after release, an IFU request is granted normally.
- m_rvalid pulsed in IDLE with no grant → neither rvalid asserts, state stays IDLE.

Source files
------------

// File: rtl/ysyx_24100006_rd_arbiter_if.sv
// Signal bundle for the 2:1 read arbiter.
// It carries three groups of signals: the IFU read channel, the LSU read channel,
// and the shared memory read port. The shared port also exposes the write
// handshakes, which the arbiter observes but never drives.
//   slave  : view taken by the arbiter
//   master : view taken by the surrounding fetch/memory stages and the bus
interface ysyx_24100006_rd_arbiter_if;

  // IFU read channel
  logic [31:0] ifu_araddr;
  logic        ifu_arvalid;
  logic        ifu_arready;
  logic [31:0] ifu_rdata;
  logic        ifu_rvalid;
  logic        ifu_rready;

  // LSU read channel
  logic [31:0] lsu_araddr;
  logic [2:0]  lsu_arsize;
  logic        lsu_arvalid;
  logic        lsu_arready;
  logic [31:0] lsu_rdata;
  logic        lsu_rvalid;
  logic        lsu_rready;

  // shared memory read port
  logic [31:0] m_araddr;
  logic [2:0]  m_arsize;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic        m_rvalid;
  logic        m_rready;

  // observed write handshakes (LSU writes bypass the arbiter)
  logic        m_awvalid;
  logic        m_awready;
  logic        m_bvalid;
  logic        m_bready;

  // status
  logic        arb_busy;

  modport slave (
    input  ifu_araddr, ifu_arvalid, ifu_rready,
    output ifu_arready, ifu_rdata, ifu_rvalid,
    input  lsu_araddr, lsu_arsize, lsu_arvalid, lsu_rready,
    output lsu_arready, lsu_rdata, lsu_rvalid,
    output m_araddr, m_arsize, m_arvalid, m_rready,
    input  m_arready, m_rdata, m_rvalid,
    input  m_awvalid, m_awready, m_bvalid, m_bready,
    output arb_busy
  );

  modport master (
    output ifu_araddr, ifu_arvalid, ifu_rready,
    input  ifu_arready, ifu_rdata, ifu_rvalid,
    output lsu_araddr, lsu_arsize, lsu_arvalid, lsu_rready,
    input  lsu_arready, lsu_rdata, lsu_rvalid,
    input  m_araddr, m_arsize, m_arvalid, m_rready,
    output m_arready, m_rdata, m_rvalid,
    output m_awvalid, m_awready, m_bvalid, m_bready,
    input  arb_busy
  );

endinterface

// File: rtl/ysyx_24100006_rd_arbiter.sv
// 2:1 single-beat read arbiter sharing one memory AR/R port between IFU and LSU.
// - A contested request normally goes to the LSU.
// - After MAX_LSU_STREAK contested LSU wins in a row, the IFU is forced through.
// - No new read is issued while a store is in flight. This keeps stores ordered
//   ahead of later loads and fetches.
// - The address and size captured at grant are held on the bus until accepted.
// - The R channel is passed straight through to the granted master.
module ysyx_24100006_rd_arbiter #(
  parameter int MAX_LSU_STREAK = 4
) (
  input logic                        clk,
  input logic                        reset,
  ysyx_24100006_rd_arbiter_if.slave  bus
);

  localparam int SW = $clog2(MAX_LSU_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LSU_STREAK);
  localparam logic [2:0]    IFU_SIZE   = 3'b010;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IFU_AR = 3'd1,
    IFU_R  = 3'd2,
    LSU_AR = 3'd3,
    LSU_R  = 3'd4
  } state_t;

  // Next value of the store-pending flag.
  // When a write address handshake and a write response land in the same cycle:
  // - If a store was already pending, the response retires it, so the flag clears.
  // - Otherwise the response belongs to nothing tracked, so the new store sets the flag.
  function automatic logic wr_pend_next(input logic cur, input logic set, input logic clr);
    logic nxt;
    if (set && clr) begin
      nxt = ~cur;
    end else if (set) begin
      nxt = 1'b1;
    end else if (clr) begin
      nxt = 1'b0;
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

  // Next value of the contested-LSU-win counter. It only moves on a grant edge.
  // The counter climbs (saturating) only while the IFU is left waiting.
  function automatic logic [SW-1:0] streak_next(input logic [SW-1:0] cur,
                                                input logic          gnt_ifu,
                                                input logic          gnt_lsu,
                                                input logic          ifu_req);
    logic [SW-1:0] nxt;
    if (gnt_ifu) begin
      nxt = '0;
    end else if (gnt_lsu) begin
      if (!ifu_req) begin
        nxt = '0;
      end else if (cur == STREAK_MAX) begin
        nxt = STREAK_MAX;
      end else begin
        nxt = cur + SW'(1);
      end
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

  state_t        state_r;
  state_t        state_nxt_s;
  logic [31:0]   araddr_r;
  logic [2:0]    arsize_r;
  logic          arvalid_r;
  logic          wr_pend_r;
  logic [SW-1:0] streak_r;

  logic          blocked_s;
  logic          gnt_ifu_s;
  logic          gnt_lsu_s;
  logic          ifu_rvalid_s;
  logic          lsu_rvalid_s;
  logic          m_rready_s;
  logic          ar_hs_s;
  logic          r_hs_s;

  // A write seen on the AW channel blocks this very cycle, before wr_pend catches up.
  assign blocked_s = wr_pend_r | bus.m_awvalid;
  assign ar_hs_s   = arvalid_r & bus.m_arready;
  assign r_hs_s    = bus.m_rvalid & m_rready_s;

  // Grant decision. It is only made in IDLE, outside reset, and with no store pending.
  always_comb begin
    gnt_ifu_s = 1'b0;
    gnt_lsu_s = 1'b0;
    if ((state_r == IDLE) && !blocked_s && !reset) begin
      if (bus.ifu_arvalid && bus.lsu_arvalid) begin
        if (streak_r == STREAK_MAX) begin
          gnt_ifu_s = 1'b1;
        end else begin
          gnt_lsu_s = 1'b1;
        end
      end else if (bus.ifu_arvalid) begin
        gnt_ifu_s = 1'b1;
      end else if (bus.lsu_arvalid) begin
        gnt_lsu_s = 1'b1;
      end else begin
        gnt_ifu_s = 1'b0;
        gnt_lsu_s = 1'b0;
      end
    end else begin
      gnt_ifu_s = 1'b0;
      gnt_lsu_s = 1'b0;
    end
  end

  // Next-state logic: grant -> address phase -> data phase -> IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (gnt_ifu_s) begin
          state_nxt_s = IFU_AR;
        end else if (gnt_lsu_s) begin
          state_nxt_s = LSU_AR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      IFU_AR: begin
        if (ar_hs_s) begin
          state_nxt_s = IFU_R;
        end else begin
          state_nxt_s = IFU_AR;
        end
      end
      LSU_AR: begin
        if (ar_hs_s) begin
          state_nxt_s = LSU_R;
        end else begin
          state_nxt_s = LSU_AR;
        end
      end
      IFU_R: begin
        if (r_hs_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = IFU_R;
        end
      end
      LSU_R: begin
        if (r_hs_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = LSU_R;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // R-channel steering: only the owner of the data phase sees rvalid and drives rready.
  always_comb begin
    ifu_rvalid_s = 1'b0;
    lsu_rvalid_s = 1'b0;
    m_rready_s   = 1'b0;
    case (state_r)
      IFU_R: begin
        ifu_rvalid_s = bus.m_rvalid;
        m_rready_s   = bus.ifu_rready;
      end
      LSU_R: begin
        lsu_rvalid_s = bus.m_rvalid;
        m_rready_s   = bus.lsu_rready;
      end
      default: begin
        ifu_rvalid_s = 1'b0;
        lsu_rvalid_s = 1'b0;
        m_rready_s   = 1'b0;
      end
    endcase
  end

  // State register; a reset drops any transfer in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Bus AR registers: capture at grant, hold until the slave accepts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      araddr_r  <= 32'h0000_0000;
      arsize_r  <= IFU_SIZE;
      arvalid_r <= 1'b0;
    end else begin
      if (gnt_ifu_s) begin
        araddr_r  <= bus.ifu_araddr;
        arsize_r  <= IFU_SIZE;
        arvalid_r <= 1'b1;
      end else if (gnt_lsu_s) begin
        araddr_r  <= bus.lsu_araddr;
        arsize_r  <= bus.lsu_arsize;
        arvalid_r <= 1'b1;
      end else if (ar_hs_s) begin
        arvalid_r <= 1'b0;
      end else begin
        arvalid_r <= arvalid_r;
      end
    end
  end

  // Store-in-flight tracker, fed from the observed write handshakes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_pend_r <= 1'b0;
    end else begin
      wr_pend_r <= wr_pend_next(wr_pend_r,
                                bus.m_awvalid & bus.m_awready,
                                bus.m_bvalid & bus.m_bready);
    end
  end

  // Fairness counter of contested LSU wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak_r <= '0;
    end else begin
      streak_r <= streak_next(streak_r, gnt_ifu_s, gnt_lsu_s, bus.ifu_arvalid);
    end
  end

  assign bus.ifu_arready = gnt_ifu_s;
  assign bus.lsu_arready = gnt_lsu_s;
  assign bus.ifu_rdata   = bus.m_rdata;
  assign bus.lsu_rdata   = bus.m_rdata;
  assign bus.ifu_rvalid  = ifu_rvalid_s;
  assign bus.lsu_rvalid  = lsu_rvalid_s;
  assign bus.m_araddr    = araddr_r;
  assign bus.m_arsize    = arsize_r;
  assign bus.m_arvalid   = arvalid_r;
  assign bus.m_rready    = m_rready_s;
  assign bus.arb_busy    = (state_r != IDLE);

endmodule

// File: tb/tb_ysyx_24100006_rd_arbiter.sv
// Directed bench for the 2:1 read arbiter (MAX_LSU_STREAK = 4).
// Inputs change 1 time unit after a rising edge.
// Outputs are sampled before the next rising edge.
module tb_ysyx_24100006_rd_arbiter;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  ysyx_24100006_rd_arbiter_if bus ();

  ysyx_24100006_rd_arbiter #(.MAX_LSU_STREAK(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [9:0] exp_ifu;
    int g;
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.ifu_araddr  = 32'h0;
    bus.ifu_arvalid = 1'b0;
    bus.ifu_rready  = 1'b1;
    bus.lsu_araddr  = 32'h0;
    bus.lsu_arsize  = 3'b010;
    bus.lsu_arvalid = 1'b0;
    bus.lsu_rready  = 1'b1;
    bus.m_arready   = 1'b0;
    bus.m_rdata     = 32'h0;
    bus.m_rvalid    = 1'b0;
    bus.m_awvalid   = 1'b0;
    bus.m_awready   = 1'b0;
    bus.m_bvalid    = 1'b0;
    bus.m_bready    = 1'b0;

    // reset state
    #3;
    check("rst_arvalid", bus.m_arvalid, 32'd0);
    check("rst_araddr", bus.m_araddr, 32'h0);
    check("rst_arsize", bus.m_arsize, 32'd2);
    check("rst_busy", bus.arb_busy, 32'd0);
    check("rst_rready", bus.m_rready, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // spurious m_rvalid in IDLE is ignored
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'hCAFE_F00D;
    #1;
    check("spur_ifu_rvalid", bus.ifu_rvalid, 32'd0);
    check("spur_lsu_rvalid", bus.lsu_rvalid, 32'd0);
    check("spur_rready", bus.m_rready, 32'd0);
    tick();
    bus.m_rvalid = 1'b0;
    check("spur_idle", bus.arb_busy, 32'd0);

    // lone IFU read, slave accepts the address late
    bus.ifu_araddr  = 32'h3000_0000;
    bus.ifu_arvalid = 1'b1;
    #1;
    check("ifu_arready_c0", bus.ifu_arready, 32'd1);
    check("ifu_lsu_arready_c0", bus.lsu_arready, 32'd0);
    tick();
    bus.ifu_arvalid = 1'b0;
    #1;
    check("ifu_arvalid_c1", bus.m_arvalid, 32'd1);
    check("ifu_araddr_c1", bus.m_araddr, 32'h3000_0000);
    check("ifu_arsize_c1", bus.m_arsize, 32'd2);
    check("ifu_arready_c1", bus.ifu_arready, 32'd0);
    check("ifu_busy_c1", bus.arb_busy, 32'd1);
    tick();
    check("ifu_arvalid_c2", bus.m_arvalid, 32'd1);
    check("ifu_araddr_c2", bus.m_araddr, 32'h3000_0000);
    tick();
    bus.m_arready = 1'b1;
    #1;
    check("ifu_arvalid_c3", bus.m_arvalid, 32'd1);
    tick();
    bus.m_arready = 1'b0;
    #1;
    check("ifu_arvalid_c4", bus.m_arvalid, 32'd0);
    check("ifu_rready_c4", bus.m_rready, 32'd1);
    check("ifu_rvalid_c4", bus.ifu_rvalid, 32'd0);
    tick();
    tick();
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'hDEAD_BEEF;
    #1;
    check("ifu_rvalid_c6", bus.ifu_rvalid, 32'd1);
    check("ifu_rdata_c6", bus.ifu_rdata, 32'hDEAD_BEEF);
    check("ifu_lsu_rvalid_c6", bus.lsu_rvalid, 32'd0);
    tick();
    bus.m_rvalid = 1'b0;
    check("ifu_idle_c7", bus.arb_busy, 32'd0);

    // LSU byte load
    bus.lsu_araddr  = 32'h8000_0003;
    bus.lsu_arsize  = 3'b000;
    bus.lsu_arvalid = 1'b1;
    #1;
    check("lb_arready", bus.lsu_arready, 32'd1);
    check("lb_ifu_arready", bus.ifu_arready, 32'd0);
    tick();
    bus.lsu_arvalid = 1'b0;
    check("lb_araddr", bus.m_araddr, 32'h8000_0003);
    check("lb_arsize", bus.m_arsize, 32'd0);
    check("lb_arvalid", bus.m_arvalid, 32'd1);
    bus.m_arready = 1'b1;
    tick();
    bus.m_arready = 1'b0;
    bus.m_rvalid  = 1'b1;
    bus.m_rdata   = 32'h1234_5678;
    #1;
    check("lb_lsu_rvalid", bus.lsu_rvalid, 32'd1);
    check("lb_ifu_rvalid", bus.ifu_rvalid, 32'd0);
    check("lb_lsu_rdata", bus.lsu_rdata, 32'h1234_5678);
    tick();
    bus.m_rvalid = 1'b0;
    check("lb_idle", bus.arb_busy, 32'd0);

    // contested requests, zero-wait slave: L,L,L,L,I repeated
    exp_ifu = 10'b10_0001_0000;
    g = 0;
    bus.ifu_araddr  = 32'h3000_0040;
    bus.lsu_araddr  = 32'h8000_0100;
    bus.lsu_arsize  = 3'b010;
    bus.ifu_arvalid = 1'b1;
    bus.lsu_arvalid = 1'b1;
    bus.m_arready   = 1'b1;
    bus.m_rvalid    = 1'b1;
    #1;
    for (int cyc = 0; cyc < 60 && g < 10; cyc++) begin
      if (bus.ifu_arready || bus.lsu_arready) begin
        check("grant_ifu", bus.ifu_arready, {31'd0, exp_ifu[g]});
        check("grant_lsu", bus.lsu_arready, {31'd0, ~exp_ifu[g]});
        g++;
      end
      tick();
    end
    check("grant_count", g, 32'd10);
    bus.ifu_arvalid = 1'b0;
    bus.lsu_arvalid = 1'b0;
    tick();
    tick();
    bus.m_arready = 1'b0;
    bus.m_rvalid  = 1'b0;
    #1;
    check("grant_idle", bus.arb_busy, 32'd0);

    // store in flight blocks a load until the write response
    bus.m_awvalid = 1'b1;
    bus.m_awready = 1'b1;
    tick();
    bus.m_awvalid   = 1'b0;
    bus.m_awready   = 1'b0;
    bus.lsu_araddr  = 32'h8000_0010;
    bus.lsu_arsize  = 3'b010;
    bus.lsu_arvalid = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      if (c == 6) begin
        bus.m_bvalid = 1'b1;
        bus.m_bready = 1'b1;
      end
      #1;
      check("store_block", bus.lsu_arready, 32'd0);
      tick();
    end
    bus.m_bvalid = 1'b0;
    bus.m_bready = 1'b0;
    #1;
    check("store_grant_c7", bus.lsu_arready, 32'd1);
    check("store_arvalid_c7", bus.m_arvalid, 32'd0);
    tick();
    bus.lsu_arvalid = 1'b0;
    check("store_arvalid_c8", bus.m_arvalid, 32'd1);
    check("store_araddr_c8", bus.m_araddr, 32'h8000_0010);

    // asynchronous reset while in LSU_R with data pending
    bus.m_arready = 1'b1;
    tick();
    bus.m_arready = 1'b0;
    bus.m_rvalid  = 1'b1;
    #1;
    check("pre_rst_rvalid", bus.lsu_rvalid, 32'd1);
    check("pre_rst_rready", bus.m_rready, 32'd1);
    reset = 1'b1;
    #1;
    check("arst_arvalid", bus.m_arvalid, 32'd0);
    check("arst_rready", bus.m_rready, 32'd0);
    check("arst_lsu_rvalid", bus.lsu_rvalid, 32'd0);
    check("arst_busy", bus.arb_busy, 32'd0);
    check("arst_araddr", bus.m_araddr, 32'h0);
    tick();
    reset        = 1'b0;
    bus.m_rvalid = 1'b0;
    tick();
    bus.ifu_araddr  = 32'h3000_0100;
    bus.ifu_arvalid = 1'b1;
    #1;
    check("post_rst_grant", bus.ifu_arready, 32'd1);
    tick();
    bus.ifu_arvalid = 1'b0;
    check("post_rst_arvalid", bus.m_arvalid, 32'd1);
    check("post_rst_araddr", bus.m_araddr, 32'h3000_0100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
